// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor_ctrl ramp sequencer.
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DWELL = 3'd4,
        ST_ESTOP = 3'd5
    } motor_state_e;

    localparam int DEADTIME_CYC_DEFAULT = 64;

    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

endpackage

// File: rtl/motor_ramp_tick.sv
// Ramp tick divider: one-cycle tick every div+1 cycles, phase restarted on request.
module motor_ramp_tick #(
    parameter int DIV_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // >= rather than == so a divider shortened mid-count still wraps promptly
    assign tick = (cnt_q >= div);

    always_ff @(posedge ACLK) begin
        if (ARESET || restart) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/motor_ramp_seq.sv
// Duty-cycle ramp sequencer with reversal dead-time and e-stop override.
// Optional: MOTOR_SEQ_SOFT_STOP_EN enables ramped (soft) stop instead of an immediate duty cut.
module motor_ramp_seq
    import motor_ctrl_pkg::*;
#(
    parameter int DUTY_W       = 16,
    parameter int DIV_W        = 16,
    parameter int DEADTIME_CYC = DEADTIME_CYC_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_enable,
    input  logic              cfg_dir,
    input  logic              cfg_estop,
    input  logic [DUTY_W-1:0] cfg_target,
    input  logic [DUTY_W-1:0] cfg_step,
    input  logic [DIV_W-1:0]  cfg_tick_div,
    output logic [DUTY_W-1:0] duty_out,
    output logic              dir_out,
    output logic              drive_en,
    output logic              busy,
    output logic [2:0]        state_out,
    output logic              fault
);

    localparam int DT_W = $clog2(DEADTIME_CYC + 1);

    // Move cur toward tgt by step, clamped at tgt; step of 0 means jump.
    // Two extra bits keep the signed sum/difference free of wrap.
    function automatic logic [DUTY_W-1:0] slew_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic signed [DUTY_W+1:0] cur_s;
        logic signed [DUTY_W+1:0] tgt_s;
        logic signed [DUTY_W+1:0] step_s;
        logic signed [DUTY_W+1:0] up_s;
        logic signed [DUTY_W+1:0] dn_s;
        cur_s  = signed'({2'b00, cur});
        tgt_s  = signed'({2'b00, tgt});
        step_s = signed'({2'b00, step});
        up_s   = cur_s + step_s;
        dn_s   = cur_s - step_s;
        if (step == '0) begin
            return tgt;
        end
        if (cur_s < tgt_s) begin
            return (up_s >= tgt_s) ? tgt : up_s[DUTY_W-1:0];
        end
        return (dn_s <= tgt_s) ? tgt : dn_s[DUTY_W-1:0];
    endfunction

    motor_state_e      state_q, state_n;
    logic [DUTY_W-1:0] duty_q, duty_n;
    logic              dir_q, dir_n;
    logic              fault_q, fault_n;
    logic              drive_en_q, busy_q;
    logic [DT_W-1:0]   dwell_q, dwell_n;
    logic [DUTY_W-1:0] ramp_duty, stop_duty;
    logic              tick, restart;

    motor_ramp_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .restart (restart),
        .div     (cfg_tick_div),
        .tick    (tick)
    );

    always_comb begin
        state_n   = state_q;
        duty_n    = duty_q;
        dir_n     = dir_q;
        fault_n   = fault_q;
        dwell_n   = dwell_q;
        ramp_duty = tick ? slew_toward(duty_q, cfg_target, cfg_step) : duty_q;
`ifdef MOTOR_SEQ_SOFT_STOP_EN
        stop_duty = tick ? slew_toward(duty_q, '0, cfg_step) : duty_q;
`else
        stop_duty = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                duty_n = '0;
                if (cfg_enable) begin
                    state_n = ST_RAMP;
                    dir_n   = cfg_dir;
                end
            end
            ST_RAMP, ST_HOLD: begin
                if (!cfg_enable || (cfg_dir != dir_q)) begin
                    state_n = ST_STOP;
`ifndef MOTOR_SEQ_SOFT_STOP_EN
                    duty_n  = '0;
`endif
                end else if (state_q == ST_RAMP) begin
                    duty_n  = ramp_duty;
                    state_n = (ramp_duty == cfg_target) ? ST_HOLD : ST_RAMP;
                end else if (cfg_target != duty_q) begin
                    state_n = ST_RAMP;
                end
            end
            ST_STOP: begin
                duty_n = stop_duty;
                if (stop_duty == '0) begin
                    if (!cfg_enable) begin
                        state_n = ST_IDLE;
                    end else if (cfg_dir != dir_q) begin
                        state_n = ST_DWELL;
                    end else begin
                        state_n = ST_RAMP;
                    end
                end
            end
            ST_DWELL: begin
                dwell_n = dwell_q + 1'b1;
                if (dwell_q == DT_W'(DEADTIME_CYC - 1)) begin
                    if (cfg_enable) begin
                        state_n = ST_RAMP;
                        dir_n   = cfg_dir;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_ESTOP: begin
                duty_n = '0;
                if (!cfg_enable) begin
                    state_n = ST_IDLE;
                    fault_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                duty_n  = '0;
            end
        endcase

        // E-stop overrides every transition, including the ESTOP exit above
        if (cfg_estop) begin
            state_n = ST_ESTOP;
            duty_n  = '0;
            fault_n = 1'b1;
        end

        if ((state_n == ST_DWELL) && (state_q != ST_DWELL)) begin
            dwell_n = '0;
        end

        restart = ((state_n == ST_RAMP) || (state_n == ST_STOP)) && (state_n != state_q);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            dir_q      <= FWD;
            fault_q    <= 1'b0;
            dwell_q    <= '0;
            drive_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            duty_q     <= duty_n;
            dir_q      <= dir_n;
            fault_q    <= fault_n;
            dwell_q    <= dwell_n;
            drive_en_q <= (state_n == ST_RAMP) || (state_n == ST_HOLD) || (state_n == ST_STOP);
            busy_q     <= (state_n == ST_RAMP) || (state_n == ST_STOP) || (state_n == ST_DWELL);
        end
    end

    assign duty_out  = duty_q;
    assign dir_out   = dir_q;
    assign drive_en  = drive_en_q;
    assign busy      = busy_q;
    assign state_out = state_q;
    assign fault     = fault_q;

endmodule
